// File: rtl/jtkcpu_busctl.sv
// jtkcpu_busctl: bus interface unit for the JTKCPU core.
// Splits one internal big-endian access of 1..MAXB bytes into DW-wide
// external bus cycles, with dtack wait states, timeout abort and bus release.
// Assumes 8*MAXB >= DW.
module jtkcpu_busctl #(
  parameter int AW   = 24,
  parameter int DW   = 8,
  parameter int MAXB = 4,
  parameter int TOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  // core side
  input  logic              req,
  input  logic              req_we,
  input  logic [AW-1:0]     req_addr,
  input  logic [2:0]        req_len,
  input  logic [8*MAXB-1:0] req_wdata,
  output logic              ack,
  output logic              berr,
  output logic [8*MAXB-1:0] rdata,
  output logic              busy,
  output logic              halted,
  // external bus
  output logic [AW-1:0]     addr,
  output logic [DW-1:0]     dout,
  input  logic [DW-1:0]     din,
  output logic              we,
  output logic              as,
  input  logic              dtack,
  input  logic              halt
);

  localparam int RW  = 8*MAXB;
  localparam int BPB = DW/8;
  localparam int WCW = $clog2(TOUT+1);
  localparam int BCW = $clog2(MAXB+1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CYC  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] HALT = 2'd3;

  logic [1:0]     st;
  logic [WCW-1:0] wcnt;
  logic [BCW-1:0] left;   // beats still to run after the current one
  logic [RW-1:0]  wbuf;   // pending write data, left-aligned

  logic [RW-1:0]  wsh;
  logic [BCW-1:0] nbeats;
  logic           bad;

  // Request decode: left-align write data, beat count and legality
  always_comb begin
    wsh    = req_wdata << (8*(MAXB - int'(req_len)));
    nbeats = (DW == 16) ? BCW'(req_len >> 1) : BCW'(req_len);
    bad    = (req_len == 3'd0) || (int'(req_len) > MAXB) ||
             ((DW == 16) && (req_addr[0] || req_len[0]));
  end

  // Bus sequencer; reset overrides cen so a stuck strobe drops immediately
  always_ff @(posedge clk) begin
    if (!rst) begin
      st     <= IDLE;
      wcnt   <= '0;
      left   <= '0;
      wbuf   <= '0;
      ack    <= 1'b0;
      berr   <= 1'b0;
      rdata  <= '0;
      busy   <= 1'b0;
      halted <= 1'b0;
      addr   <= '0;
      dout   <= '0;
      we     <= 1'b0;
      as     <= 1'b0;
    end else if (cen) begin
      ack  <= 1'b0;
      berr <= 1'b0;
      case (st)
        IDLE: begin
          if (halt) begin
            st     <= HALT;
            halted <= 1'b1;
          end else if (req && !ack) begin
            // !ack keeps a request that is still held during its own ack
            // cycle from being accepted a second time
            if (bad) begin
              ack  <= 1'b1;
              berr <= 1'b1;
            end else begin
              busy  <= 1'b1;
              addr  <= req_addr;
              we    <= req_we;
              dout  <= wsh[RW-1 -: DW];
              wbuf  <= wsh << DW;
              left  <= nbeats - BCW'(1);
              rdata <= '0;
              wcnt  <= '0;
              as    <= 1'b1;
              st    <= CYC;
            end
          end
        end
        HALT: begin
          if (!halt) begin
            st     <= IDLE;
            halted <= 1'b0;
          end
        end
        CYC: begin
          if (dtack) begin
            wcnt <= '0;
            as   <= 1'b0;
            if (!we) rdata <= (rdata << DW) | RW'(din);
            if (left != '0) begin
              left <= left - BCW'(1);
              addr <= addr + AW'(BPB);
              dout <= wbuf[RW-1 -: DW];
              wbuf <= wbuf << DW;
              st   <= GAP;
            end else begin
              we   <= 1'b0;
              ack  <= 1'b1;
              busy <= 1'b0;
              st   <= IDLE;
            end
          end else if (wcnt == WCW'(TOUT)) begin
            // target never answered: abort, partial read data is kept
            wcnt <= '0;
            as   <= 1'b0;
            we   <= 1'b0;
            ack  <= 1'b1;
            berr <= 1'b1;
            busy <= 1'b0;
            st   <= IDLE;
          end else begin
            wcnt <= wcnt + WCW'(1);
          end
        end
        default: begin  // GAP
          as <= 1'b1;
          st <= CYC;
        end
      endcase
    end
  end

endmodule

// File: doc/jtkcpu_busctl.md
# jtkcpu_busctl

Parametrised bus interface unit for the JTKCPU core: it turns one internal multi-byte access request (1..MAXB bytes, big-endian) into a sequence of external bus cycles of width DW. It drives address strobe and write enable, stretches cycles on `dtack`, aborts on a timeout, and releases the bus on `halt`. It sits between the core sequencer/memory controller and the external `addr`/`din`/`dout`/`as`/`we` pins.

## Interface
- `AW`, 24, external address width.
- `DW`, 8, external data width. Legal values: 8 or 16.
- `MAXB`, 4, maximum bytes per request.
- `TOUT`, 255, number of cen-qualified wait cycles before a bus error is raised.

- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock, synchronous, active-low: `rst`=0 resets on the `clk` edge.
- `cen`  in  1  clock enable. All state advances only on edges where `cen`=1.
- `req`  in  1  request. Sampled in IDLE; must be held until `ack`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  AW  address of the first (most significant) byte.
- `req_len`  in  3  byte count, 1..MAXB.
- `req_wdata`  in  8*MAXB  write data, right-aligned; byte at `req_addr` = `req_wdata[8*req_len-1 -: 8]`.
- `ack`  out  1  completion pulse, one cen period.
- `berr`  out  1  error flag, valid with `ack`.
- `rdata`  out  8*MAXB  read data, right-aligned, unused upper bytes 0.
- `busy`  out  1  transaction in progress.
- `halted`  out  1  bus released due to `halt`.
- `addr`  out  AW  external address.
- `dout`  out  DW  external write data.
- `din`  in  DW  external read data.
- `we`  out  1  external write enable.
- `as`  out  1  address strobe.
- `dtack`  in  1  data acknowledge from the target.
- `halt`  in  1  bus release request.

## Operation
- States: IDLE, CYC (`as`=1), GAP (`as`=0 between beats), HALT.
- IDLE, `halt`=1: go to HALT; `halted`=1, `as`=0. Leave HALT when `halt`=0. A pending `req` waits.
- IDLE, `req`=1, `halt`=0:
  - Latch the request, `busy`=1. Beats = ceil(8*`req_len`/DW).
  - Drive `addr`=`req_addr`, `we`=`req_we`, `dout` = first DW bits (MSB first), `as`=1. Go to CYC.
- Illegal request gives `ack`=1, `berr`=1 on the next cen with no bus cycle. Illegal means:
  - `req_len`=0 or `req_len`>MAXB;
  - DW=16 with `req_addr[0]`=1;
  - DW=16 with odd `req_len`.
- CYC: the wait counter increments on each cen edge with `dtack`=0.
  - `dtack`=1: capture `din` into the next-lower slot of `rdata` (reads), clear the wait counter.
  - If beats remain: `addr` += DW/8, modulo 2^AW (wraps from all-ones to 0). Load the next `dout`, `as`=0, go to GAP.
  - Otherwise: `as`=0, `we`=0, `ack`=1, `busy`=0, go to IDLE.
- GAP: on the next cen, `as`=1, go to CYC.
- Timeout: the wait counter reaches TOUT in CYC. Then `as`=0, `we`=0, `ack`=1, `berr`=1, go to IDLE.
  - Partial read data stays in `rdata`.
- `halt` asserted mid-transaction is ignored until the return to IDLE; transactions are never split.
- `ack` and `berr` clear on the next cen edge.

## Timing
- Reset values: `as`=0, `we`=0, `addr`=0, `dout`=0, `ack`=0, `berr`=0, `busy`=0, `halted`=0, `rdata`=0, state IDLE, wait counter 0.
- Reset mid-transaction: `as` drops on the reset edge. No `ack` is produced.
- Latencies in cen edges after acceptance (edge 0), with w_i = wait cycles of beat i:
  - Single beat: `ack` high after edge 1+w.
  - N beats: `ack` after 2N−1+Σw_i.
- Outputs change only on cen edges and hold between them.
- `halt` to `halted`: 1 cen edge when the unit is IDLE.
- `dtack` is sampled only while `as`=1 in CYC; `dtack` during GAP/IDLE is ignored.

## Test plan
- DW=8, read, `req_len`=2, `req_addr`=0x00FFFF, `din`=0x12 then 0x34, `dtack` always 1:
  - `addr` goes 0x00FFFF, then 0x010000.
  - `rdata`=0x1234; `ack` after edge 3; `berr`=0.
- DW=8, write, `req_len`=4, `req_wdata`=0xDEADBEEF:
  - `dout` sequence DE, AD, BE, EF, with `we`=1 each beat.
  - `as` low one cen between beats; `ack` after edge 7.
- DW=16, read, `req_len`=4, `req_addr`=0xFFFFFE, `dtack` delayed 3 cycles on beat 1:
  - Second address is 0x000000 (wrap).
  - `ack` after edge 6.
  - Also: odd `req_addr` gives `berr`=1 with no `as` pulse.
- TOUT=4, `dtack` stuck at 0:
  - `ack`=`berr`=1 after edge 5; `as`=0 afterwards.
- `halt` raised during beat 2 of a 3-beat write:
  - The transaction completes.
  - `halted`=1 one cen after `ack`.
  - A new `req` stays blocked until `halt`=0.
- `rst`=0 while in CYC:
  - All outputs return to reset values on that edge.
  - `cen`=0 cycles freeze state and outputs.
